// File: rtl/serial_add.sv
// Digit-serial adder/subtractor: WIDTH/DIGIT cycles from the accepting start edge to the done pulse.
// No backpressure: start is ignored while busy and accepted again in the done cycle.
module serial_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       opa;
  logic [WIDTH-1:0]       opb;
  logic [WIDTH-1:0]       acc;
  logic                   carry;
  logic [CW-1:0]          cnt;

  logic [DIGIT-1:0]       slice_s;
  logic                   cy_out;
  logic                   cy_msb;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;

  // Ripple through DIGIT full adders; cy_msb is the carry into the top cell of the slice.
  always_comb begin
    slice_s = '0;
    cy_out  = carry;
    cy_msb  = carry;
    for (int i = 0; i < DIGIT; i++) begin
      cy_msb     = cy_out;
      slice_s[i] = opa[i] ^ opb[i] ^ cy_out;
      cy_out     = (opa[i] & opb[i]) | (cy_out & (opa[i] ^ opb[i]));
    end
  end

  // Partial sum fills from the top so the last slice lands the word in place.
  assign acc_cat  = {slice_s, acc};
  assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= cin ^ sub;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          done  <= 1'b0;
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          carry <= cy_out;
          acc   <= acc_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= cy_out;
            ovf   <= cy_out ^ cy_msb;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add: five parameterisations checked against an arithmetic model,
// including acceptance timing, ignored starts, reset mid-operation and exhaustive 4-bit cases.
module tb_serial_add;

  localparam int WD[5] = '{8, 8, 4, 4, 4};
  localparam int ND[5] = '{8, 2, 4, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] av[5];
  logic [7:0] bv[5];
  logic       st[5];
  logic       ci[5];
  logic       sb[5];
  logic       bz[5];
  logic       dn[5];
  logic       co[5];
  logic       ov[5];
  logic [7:0] sm[5];
  logic [7:0] s81, s84;
  logic [3:0] s41, s42, s44;

  always #5 clk = ~clk;

  serial_add #(.WIDTH(8), .DIGIT(1)) u81 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]), .cin(ci[0]), .sub(sb[0]),
    .busy(bz[0]), .done(dn[0]), .sum(s81), .cout(co[0]), .ovf(ov[0]));
  serial_add #(.WIDTH(8), .DIGIT(4)) u84 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]), .cin(ci[1]), .sub(sb[1]),
    .busy(bz[1]), .done(dn[1]), .sum(s84), .cout(co[1]), .ovf(ov[1]));
  serial_add #(.WIDTH(4), .DIGIT(1)) u41 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2][3:0]), .b(bv[2][3:0]), .cin(ci[2]), .sub(sb[2]),
    .busy(bz[2]), .done(dn[2]), .sum(s41), .cout(co[2]), .ovf(ov[2]));
  serial_add #(.WIDTH(4), .DIGIT(2)) u42 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .a(av[3][3:0]), .b(bv[3][3:0]), .cin(ci[3]), .sub(sb[3]),
    .busy(bz[3]), .done(dn[3]), .sum(s42), .cout(co[3]), .ovf(ov[3]));
  serial_add #(.WIDTH(4), .DIGIT(4)) u44 (
    .clk(clk), .rst_n(rst_n), .start(st[4]), .a(av[4][3:0]), .b(bv[4][3:0]), .cin(ci[4]), .sub(sb[4]),
    .busy(bz[4]), .done(dn[4]), .sum(s44), .cout(co[4]), .ovf(ov[4]));

  assign sm[0] = s81;
  assign sm[1] = s84;
  assign sm[2] = {4'h0, s41};
  assign sm[3] = {4'h0, s42};
  assign sm[4] = {4'h0, s44};

  typedef struct {
    int sum;
    bit cout;
    bit ovf;
    int issue;
  } exp_t;

  exp_t q[5][$];
  int   next_ok[5];
  int   last_sum[5];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result from plain integer arithmetic; overflow from the signed-range test.
  function automatic exp_t model(int w, int x, int y, bit c, bit s);
    exp_t r;
    int m, ye, ce, u, half, sx, sy, ss;
    m    = (1 << w) - 1;
    x    = x & m;
    y    = y & m;
    ye   = s ? (~y & m) : y;
    ce   = s ? (c ? 0 : 1) : (c ? 1 : 0);
    u    = x + ye + ce;
    half = 1 << (w - 1);
    sx   = (x >= half) ? x - (1 << w) : x;
    sy   = (ye >= half) ? ye - (1 << w) : ye;
    ss   = sx + sy + ce;
    r.sum   = u & m;
    r.cout  = ((u >> w) & 1) == 1;
    r.ovf   = (ss >= half) || (ss < -half);
    r.issue = 0;
    return r;
  endfunction

  task automatic check(input string name, input int inst, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  // Called at a falling edge; a start is booked only if the next rising edge would accept it.
  task automatic drive(input int i, input int x, input int y, input bit c, input bit s, input bit go);
    int   iss;
    exp_t e;
    av[i] = x[7:0];
    bv[i] = y[7:0];
    ci[i] = c;
    sb[i] = s;
    st[i] = go;
    iss = cyc + 1;
    if (go && iss >= next_ok[i]) begin
      e = model(WD[i], x, y, c, s);
      e.issue = iss;
      q[i].push_back(e);
      next_ok[i] = iss + ND[i] + 1;
    end
  endtask

  task automatic stop(input int i);
    st[i] = 1'b0;
    av[i] = 8'($urandom_range(0, 255));
    bv[i] = 8'($urandom_range(0, 255));
    ci[i] = 1'($urandom_range(0, 1));
    sb[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    bit empty;
    empty = 1'b0;
    for (int k = 0; k < 300 && !empty; k++) begin
      @(negedge clk);
      empty = 1'b1;
      for (int i = 0; i < 5; i++) if (q[i].size() != 0) empty = 1'b0;
    end
    if (!empty) begin
      tests++;
      fails++;
      $display("FAIL timeout: results still pending after 300 cycles");
      for (int i = 0; i < 5; i++) q[i].delete();
    end
  endtask

  task automatic op(input int i, input int x, input int y, input bit c, input bit s);
    @(negedge clk);
    drive(i, x, y, c, s, 1'b1);
    @(negedge clk);
    stop(i);
    wait_idle();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 5; i++) begin
        exp_t e;
        if (dn[i]) begin
          if (q[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done inst%0d: done=1 with no operation pending", i);
          end else begin
            e = q[i].pop_front();
            check("sum", i, int'(sm[i]), e.sum);
            check("cout", i, int'(co[i]), int'(e.cout));
            check("ovf", i, int'(ov[i]), int'(e.ovf));
            check("latency", i, cyc - e.issue, ND[i]);
            check("busy_in_done", i, int'(bz[i]), 0);
            last_sum[i] = e.sum;
          end
        end else if (bz[i]) begin
          check("sum_hold", i, int'(sm[i]), last_sum[i]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      st[i] = 1'b0; av[i] = '0; bv[i] = '0; ci[i] = 1'b0; sb[i] = 1'b0;
      next_ok[i] = 0; last_sum[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("rst_busy", i, int'(bz[i]), 0);
      check("rst_done", i, int'(dn[i]), 0);
      check("rst_sum", i, int'(sm[i]), 0);
      check("rst_cout", i, int'(co[i]), 0);
      check("rst_ovf", i, int'(ov[i]), 0);
    end
    #3 rst_n = 1'b1;

    // Directed WIDTH=8 cases
    op(0, 'hFF, 'h01, 1'b0, 1'b0);
    op(0, 'h7F, 'h01, 1'b0, 1'b0);
    op(0, 'h05, 'h07, 1'b0, 1'b1);
    op(1, 'hA5, 'h5A, 1'b1, 1'b0);

    // start held high on DIGIT=4: accepted again in the done cycle
    @(negedge clk);
    drive(1, 'hA5, 'h5A, 1'b1, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      drive(1, 'h12, 'h34, 1'b0, 1'b1, 1'b1);
    end
    @(negedge clk);
    stop(1);
    wait_idle();

    // start 3 cycles into RUN with other operands must be ignored
    @(negedge clk);
    drive(0, 'h33, 'h44, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    stop(0);
    repeat (2) @(negedge clk);
    drive(0, 'h01, 'h02, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    stop(0);
    wait_idle();

    // Reset mid-RUN: outputs clear at once, no done pulse
    @(negedge clk);
    drive(0, 'h55, 'h66, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    stop(0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q[i].delete();
      next_ok[i] = 0;
      last_sum[i] = 0;
    end
    #1;
    check("midrst_busy", 0, int'(bz[0]), 0);
    check("midrst_done", 0, int'(dn[0]), 0);
    check("midrst_sum", 0, int'(sm[0]), 0);
    check("midrst_cout", 0, int'(co[0]), 0);
    check("midrst_ovf", 0, int'(ov[0]), 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    op(0, 'h10, 'h20, 1'b0, 1'b0);

    // Random traffic with random start timing on the 8-bit instances
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        drive(i, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    stop(0);
    stop(1);
    wait_idle();

    // Exhaustive WIDTH=4 for DIGIT 1, 2, 4
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int cs = 0; cs < 4; cs++) begin
          @(negedge clk);
          for (int i = 2; i < 5; i++) drive(i, x, y, cs[0], cs[1], 1'b1);
          @(negedge clk);
          for (int i = 2; i < 5; i++) stop(i);
          wait_idle();
        end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
